pulse_width_meter: RTL and testbench

Receive-side companion to the timer. Measures the high time of an incoming pulse (for example a timer out_pulse) in clock cycles and presents each result on a valid/ready output. It includes an optional input synchronizer, rise/fall detection, a saturating width counter, and a one-entry result register with an overrun flag. It is used to check timer load values in-system and to decode pulse-width-coded control signals.

---
 rtl/pulse_width_meter_pkg.sv | 9 +
 rtl/pulse_width_meter_sync_edge.sv | 51 +++++
 rtl/pulse_width_meter.sv | 106 ++++++++++
 tb/tb_pulse_width_meter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_width_meter_pkg.sv
// Shared types for the pulse width meter: measurement FSM state encoding.
package pulse_width_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pulse_width_meter_sync_edge.sv
// Input conditioning for the pulse width meter: optional synchronizer chain,
// one-cycle delayed sample and rise/fall strobes. All flops reset to 1 so a
// pulse already high when reset releases never shows up as a rising edge.
module pwm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic s_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = pulse_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] chain;

      // Synchronizer shift chain; stage 0 samples the raw input.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          chain <= '1;
        end else begin
          chain[0] <= pulse_in;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign s = chain[SYNC_STAGES-1];
    end
  endgenerate

  // One-cycle delayed copy of the synchronized sample for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_d <= 1'b1;
    end else begin
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pulse_width_meter.sv
// Pulse high-time meter: counts consecutive high samples of the conditioned
// input with saturation, then posts width/ovf on a valid/ready result
// register that flags an overwritten unconsumed result via miss.
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int unsigned N           = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pulse_in,
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] width,
  output logic         ovf,
  output logic         miss,
  output logic         busy
);

  pwm_state_e   state;
  pwm_state_e   state_next;
  logic         s;
  logic         rise;
  logic         fall;
  logic [N-1:0] cnt;
  logic         ovf_acc;
  logic         load;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .s        (s),
    .rise     (rise),
    .fall     (fall)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start on a rising edge, finish on the falling edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = MEAS;
      MEAS:    if (fall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: busy while measuring, result load on the terminating fall.
  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    if (state == MEAS) begin
      busy = 1'b1;
      load = fall;
    end
  end

  // Saturating width counter; the rising sample itself counts as cycle 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (state == IDLE && rise) begin
      cnt     <= N'(1);
      ovf_acc <= 1'b0;
    end else if (state == MEAS && s) begin
      if (&cnt) begin
        ovf_acc <= 1'b1;
      end else begin
        cnt <= cnt + N'(1);
      end
    end
  end

  // Result register with handshake; a load takes priority over an accept,
  // and miss reports only an overwrite of a result nobody consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      width <= '0;
      ovf   <= 1'b0;
      miss  <= 1'b0;
    end else if (load) begin
      width <= cnt;
      ovf   <= ovf_acc;
      valid <= 1'b1;
      miss  <= valid & ~ready;
    end else if (valid && ready) begin
      valid <= 1'b0;
      miss  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter (N=5, SYNC_STAGES=2): inputs driven on
// the falling clock edge, outputs checked on the falling edge.
module tb_pulse_width_meter;

  logic       clk;
  logic       rst;
  logic       pulse_in;
  logic       ready;
  logic       valid;
  logic [4:0] width;
  logic       ovf;
  logic       miss;
  logic       busy;

  int unsigned vectors;
  int unsigned miscompares;

  pulse_width_meter #(
    .N           (5),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .ready    (ready),
    .valid    (valid),
    .width    (width),
    .ovf      (ovf),
    .miss     (miss),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // High for k sampled cycles; returns on the negedge where pulse_in drops.
  task automatic pulse(input int unsigned k);
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (k) @(negedge clk);
    pulse_in = 1'b0;
  endtask

  // Pulse then wait to the first negedge where the result must be visible.
  task automatic pulse_wait(input int unsigned k);
    pulse(k);
    repeat (3) @(negedge clk);
  endtask

  // Hold ready for exactly one rising edge.
  task automatic accept();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    logic        all_busy;
    logic        saw_valid;
    logic [11:0] pat;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    pulse_in    = 1'b0;
    ready       = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_width", width, 0);
    chk("rst_ovf",   ovf,   0);
    chk("rst_miss",  miss,  0);
    chk("rst_busy",  busy,  0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_valid", valid, 0);

    // Normal 4-cycle pulse, latency and hold
    pulse(4);
    @(negedge clk);
    chk("p4_lat1_valid", valid, 0);
    @(negedge clk);
    chk("p4_lat2_valid", valid, 0);
    @(negedge clk);
    chk("p4_valid", valid, 1);
    chk("p4_width", width, 4);
    chk("p4_ovf",   ovf,   0);
    chk("p4_miss",  miss,  0);
    chk("p4_busy",  busy,  0);
    repeat (3) @(negedge clk);
    chk("p4_hold_valid", valid, 1);
    chk("p4_hold_width", width, 4);
    accept();
    chk("p4_acc_valid", valid, 0);
    chk("p4_acc_miss",  miss,  0);
    chk("p4_acc_width", width, 4);

    // Overflow: 40-cycle pulse, busy throughout
    all_busy = 1'b1;
    @(negedge clk);
    pulse_in = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i >= 3) all_busy = all_busy & busy;
    end
    pulse_in = 1'b0;
    for (int i = 41; i <= 42; i++) begin
      @(negedge clk);
      all_busy = all_busy & busy;
    end
    chk("ovf_busy_all", all_busy, 1);
    @(negedge clk);
    chk("ovf_busy_end", busy,  0);
    chk("ovf_valid",    valid, 1);
    chk("ovf_width",    width, 31);
    chk("ovf_flag",     ovf,   1);
    accept();
    chk("ovf_acc_valid", valid, 0);
    chk("ovf_acc_ovf",   ovf,   1);

    // Exactly 2^N-1 cycles: no overflow
    pulse_wait(31);
    chk("p31_valid", valid, 1);
    chk("p31_width", width, 31);
    chk("p31_ovf",   ovf,   0);
    accept();

    // Minimum pulse
    pulse_wait(1);
    chk("p1_valid", valid, 1);
    chk("p1_width", width, 1);
    chk("p1_ovf",   ovf,   0);
    accept();
    chk("p1_acc_valid", valid, 0);

    // Split: high 3, low 1, high 5
    pat = 12'b0001_1111_0111;
    @(negedge clk);
    pulse_in = pat[0];
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i < 12) pulse_in = pat[i];
      if (i == 6) begin
        chk("split1_valid", valid, 1);
        chk("split1_width", width, 3);
        ready = 1'b1;
      end
      if (i == 7) begin
        ready = 1'b0;
        chk("split1_acc_valid", valid, 0);
      end
    end
    chk("split2_valid", valid, 1);
    chk("split2_width", width, 5);
    chk("split2_miss",  miss,  0);
    accept();

    // Overrun: 3 then 6 with ready low
    pulse_wait(3);
    chk("orun1_width", width, 3);
    chk("orun1_miss",  miss,  0);
    pulse_wait(6);
    chk("orun2_valid", valid, 1);
    chk("orun2_width", width, 6);
    chk("orun2_miss",  miss,  1);
    accept();
    chk("orun_acc_valid", valid, 0);
    chk("orun_acc_miss",  miss,  0);

    // Load coincident with accept
    pulse_wait(4);
    chk("sim1_width", width, 4);
    pulse(7);
    @(negedge clk);
    @(negedge clk);
    ready = 1'b1;
    chk("sim_pre_valid", valid, 1);
    chk("sim_pre_width", width, 4);
    @(negedge clk);
    ready = 1'b0;
    chk("sim_valid", valid, 1);
    chk("sim_width", width, 7);
    chk("sim_miss",  miss,  0);
    accept();

    // Reset in the middle of a 10-cycle pulse
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_busy",  busy,  0);
    chk("rmid_width", width, 0);
    @(negedge clk);
    rst = 1'b1;
    saw_valid = 1'b0;
    for (int i = 7; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) pulse_in = 1'b0;
      saw_valid = saw_valid | valid | busy;
    end
    chk("rmid_no_result", saw_valid, 0);
    pulse_wait(4);
    chk("rmid_next_valid", valid, 1);
    chk("rmid_next_width", width, 4);
    chk("rmid_next_ovf",   ovf,   0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
